// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle for axi_lite_sram_slave.
// Carries the AR/R read channels and the AW/W/B write channels.
//   master modport: initiator side; drives addresses, write data, valids and rready/bready.
//   slave  modport: responder side; drives the readys, read data and responses.
interface axi_lite_sram_slave_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-organised memory array.
// One read and one write transaction are served at a time, each with a
// programmable response latency. Out-of-range accesses answer SLVERR.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (control state only; memory kept)
//   bus  - axi_lite_sram_slave_if.slave: AR/R/AW/W/B channels
module axi_lite_sram_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_sram_slave_if.slave bus
);
  localparam int          IW       = $clog2(DEPTH);
  localparam logic [32:0] TOP_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  // 33-bit compare so a window touching the top of the address space cannot wrap.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < TOP_ADDR);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  // ---------------- read path ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  rstate_t     rstate;
  logic [3:0]  rcnt;
  logic [31:0] ar_addr;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        rvalid_r;
  logic [31:0] rd_addr;
  logic        rd_load;
  logic        rd_hit;
  logic [31:0] rd_word;

  // With zero latency the response is loaded on the AR handshake edge itself,
  // so the address comes straight from the bus rather than the latch.
  assign rd_addr = (rstate == R_IDLE) ? bus.araddr : ar_addr;
  assign rd_load = ((rstate == R_IDLE) && bus.arvalid && (READ_LAT == 0)) ||
                   ((rstate == R_WAIT) && (rcnt == 4'd1));
  assign rd_hit  = in_range(rd_addr);
  assign rd_word = mem[word_idx(rd_addr)];

  assign bus.arready = !rst && (rstate == R_IDLE);
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rvalid  = rvalid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      rcnt     <= 4'd0;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0;
      rresp_r  <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (bus.arvalid) begin
            ar_addr <= bus.araddr;
            if (READ_LAT == 0) begin
              rstate <= R_RESP;
            end else begin
              rcnt   <= 4'(READ_LAT);
              rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          rcnt <= rcnt - 4'd1;
          if (rcnt == 4'd1) rstate <= R_RESP;
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_r <= 1'b0;
            rstate   <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
      // A write committing to the same word on this edge is not yet visible,
      // so the read returns the old contents.
      if (rd_load) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_hit ? rd_word : 32'h0;
        rresp_r  <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  wstate_t     wstate;
  logic [3:0]  wcnt;
  logic        aw_full;
  logic        w_full;
  logic [31:0] aw_buf;
  logic [31:0] w_buf;
  logic [3:0]  ws_buf;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic        aw_cap;
  logic        w_cap;
  logic        both_full;
  logic        commit;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_hit;
  logic        unused_wstrb_hi;

  assign unused_wstrb_hi = ^bus.wstrb[7:4];

  assign bus.awready = !rst && (wstate == W_IDLE) && !aw_full;
  assign bus.wready  = !rst && (wstate == W_IDLE) && !w_full;
  assign bus.bresp   = bresp_r;
  assign bus.bvalid  = bvalid_r;

  assign aw_cap    = bus.awvalid && bus.awready;
  assign w_cap     = bus.wvalid && bus.wready;
  assign both_full = (aw_full || aw_cap) && (w_full || w_cap);

  // The commit is performed on the edge that leaves the wait (or the capture
  // edge when there is no wait), which puts bvalid exactly 1+WRITE_LAT cycles
  // after the last capture. Same-cycle captures bypass the empty buffers.
  assign wr_addr = aw_full ? aw_buf : bus.awaddr;
  assign wr_data = w_full ? w_buf : bus.wdata;
  assign wr_strb = w_full ? ws_buf : bus.wstrb[3:0];
  assign wr_hit  = in_range(wr_addr);
  assign commit  = !rst &&
                   (((wstate == W_IDLE) && both_full && (WRITE_LAT == 0)) ||
                    ((wstate == W_WAIT) && (wcnt == 4'd1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate   <= W_IDLE;
      wcnt     <= 4'd0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_r <= 1'b0;
      bresp_r  <= OKAY;
    end else begin
      if (aw_cap) begin
        aw_full <= 1'b1;
        aw_buf  <= bus.awaddr;
      end
      if (w_cap) begin
        w_full <= 1'b1;
        w_buf  <= bus.wdata;
        ws_buf <= bus.wstrb[3:0];
      end
      case (wstate)
        W_IDLE: begin
          if (both_full) begin
            if (WRITE_LAT == 0) begin
              wstate <= W_RESP;
            end else begin
              wcnt   <= 4'(WRITE_LAT);
              wstate <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) wstate <= W_RESP;
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_r <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
      if (commit) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_hit ? OKAY : SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) mem[word_idx(wr_addr)][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench for axi_lite_sram_slave: directed and randomized AXI-Lite
// transactions, expected responses queued at issue time from a word-array model
// and compared by a monitor on each R/B handshake.
module tb_axi_lite_sram_slave;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          RL    = 2;
  localparam int          WL    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  axi_lite_sram_slave_if bus();

  axi_lite_sram_slave #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word array indexed by word number, plain arithmetic decode.
  logic [31:0] model [int];
  logic [33:0] rq [$];
  logic [1:0]  bq [$];

  function automatic bit m_in(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compare on the falling edge preceding each handshake edge.
  always @(negedge clk) begin
    logic [33:0] re;
    logic [1:0]  be;
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk1("r_unexpected", bus.rvalid, 1'b0);
      else begin
        re = rq.pop_front();
        check("rresp", 32'(bus.rresp), 32'(re[33:32]));
        check("rdata", bus.rdata, re[31:0]);
      end
    end
    if (bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk1("b_unexpected", bus.bvalid, 1'b0);
      else begin
        be = bq.pop_front();
        check("bresp", 32'(bus.bresp), 32'(be));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [33:0] e;
    int t;
    int hs;
    e = m_in(a) ? {2'b00, model[m_idx(a)]} : {2'b10, 32'h0};
    rq.push_back(e);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin step(); t++; end
    hs = cyc;
    step();
    bus.arvalid = 1'b0;
    bus.araddr  = $urandom();
    t = 0;
    while (!bus.rvalid && t < 40) begin step(); t++; end
    check("r_latency", 32'(cyc - hs), 32'(1 + RL));
    for (int i = 0; i < hold; i++) begin
      chk1("r_hold_valid", bus.rvalid, 1'b1);
      check("r_hold_data", bus.rdata, e[31:0]);
      chk1("r_hold_arready", bus.arready, 1'b0);
      step();
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk1("arready_after_r", bus.arready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          input int aw_dly, input int w_dly, input int hold);
    logic [1:0]  e;
    logic [31:0] w;
    int t, p, last;
    bit awp, wp;
    if (m_in(a)) begin
      w = model.exists(m_idx(a)) ? model[m_idx(a)] : 32'h0;
      for (int k = 0; k < 4; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
      model[m_idx(a)] = w;
      e = 2'b00;
    end else begin
      e = 2'b10;
    end
    bq.push_back(e);
    awp = 1; wp = 1; p = 0; last = cyc;
    while ((awp || wp) && p < 40) begin
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = awp && (p >= aw_dly);
      bus.wvalid  = wp && (p >= w_dly);
      if (!wp && awp) begin
        chk1("wready_after_w", bus.wready, 1'b0);
        chk1("awready_waiting", bus.awready, 1'b1);
      end
      if (!awp && wp) begin
        chk1("awready_after_aw", bus.awready, 1'b0);
        chk1("wready_waiting", bus.wready, 1'b1);
      end
      if (bus.awvalid && bus.awready) begin awp = 0; last = cyc; end
      if (bus.wvalid && bus.wready) begin wp = 0; last = cyc; end
      step();
      p++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk1("aw_w_captured", awp || wp, 1'b0);
    t = 0;
    while (!bus.bvalid && t < 40) begin step(); t++; end
    check("b_latency", 32'(cyc - last), 32'(1 + WL));
    for (int i = 0; i < hold; i++) begin
      chk1("b_hold_valid", bus.bvalid, 1'b1);
      check("b_hold_resp", 32'(bus.bresp), 32'(e));
      chk1("b_hold_awready", bus.awready, 1'b0);
      chk1("b_hold_wready", bus.wready, 1'b0);
      step();
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk1("awready_after_b", bus.awready, 1'b1);
    chk1("wready_after_b", bus.wready, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = BASE - 32'd4;
      1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
      2: a = ($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
      default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endcase
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail %0d", n_fail);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bit seen;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.wvalid = 0; bus.bready = 0;
    rst = 1'b1;
    repeat (3) step();
    chk1("rst_arready", bus.arready, 1'b0);
    chk1("rst_awready", bus.awready, 1'b0);
    chk1("rst_wready", bus.wready, 1'b0);
    chk1("rst_rvalid", bus.rvalid, 1'b0);
    chk1("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rresp", 32'(bus.rresp), 32'h0);
    check("rst_bresp", 32'(bus.bresp), 32'h0);
    rst = 1'b0;
    #1;
    chk1("idle_arready", bus.arready, 1'b1);
    chk1("idle_awready", bus.awready, 1'b1);
    chk1("idle_wready", bus.wready, 1'b1);
    step();

    // Preload the word window used by the rest of the run, plus the last word.
    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom(), 8'h0F, 0, 0, 0);
    do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom(), 8'h0F, 0, 0, 0);

    // Single write then read-back.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 0);
    do_read(32'h8000_0010, 0);

    // Byte strobes, upper strobe bits ignored.
    do_write(BASE + 32'd20, 32'h1122_3344, 8'h0F, 0, 0, 0);
    do_write(BASE + 32'd20, 32'hAABB_CCDD, 8'h05, 0, 0, 0);
    do_read(BASE + 32'd20, 0);
    do_write(BASE + 32'd20, 32'h1122_3344, 8'h0F, 0, 0, 0);
    do_write(BASE + 32'd20, 32'hAABB_CCDD, 8'hF5, 0, 0, 0);
    do_read(BASE + 32'd20, 0);

    // W leads AW by 3 cycles, then AW leads W.
    do_write(BASE + 32'd24, $urandom(), 8'h0F, 3, 0, 0);
    do_read(BASE + 32'd24, 0);
    do_write(BASE + 32'd28, $urandom(), 8'h0F, 0, 2, 0);
    do_read(BASE + 32'd28, 0);

    // Out of range and boundary words.
    do_read(32'h7FFF_FFFC, 0);
    do_read(32'h8000_1000, 0);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 0);
    do_write(32'h8000_1000, 32'h1234_5678, 8'h0F, 0, 0, 0);
    do_read(BASE, 0);

    // Zero strobe in range.
    do_write(BASE + 32'd8, 32'hFFFF_FFFF, 8'h00, 0, 0, 0);
    do_read(BASE + 32'd8, 0);

    // Backpressure on R and B.
    do_read(BASE + 32'd12, 5);
    do_write(BASE + 32'd12, $urandom(), 8'h0F, 0, 0, 5);
    do_read(BASE + 32'd12, 0);

    // Reset during the read wait: the read is dropped.
    bus.araddr  = BASE + 32'd4;
    bus.arvalid = 1'b1;
    chk1("mid_rst_arready_pre", bus.arready, 1'b1);
    step();
    bus.arvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mid_rst_arready_forced", bus.arready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("mid_rst_arready_after", bus.arready, 1'b1);
    seen = 0;
    repeat (6) begin seen |= bus.rvalid; step(); end
    chk1("mid_rst_no_rvalid", seen, 1'b0);
    do_read(BASE + 32'd4, 0);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_read(rand_addr(), $urandom_range(0, 3));
      else
        do_write(rand_addr(), $urandom(), 8'($urandom()), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) step();
    check("r_queue_left", 32'(rq.size()), 32'h0);
    check("b_queue_left", 32'(bq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
